// File: rtl/serial_adder.sv
// Bit-serial adder: one sum bit per clock, LSB first, through a single carry flop.
// The result registers update only on completion, so sum/cout hold between operations.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic s1, c1, sbit, c2;

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    acc_d   = acc_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    // Two half adders plus a carry-merge OR form the per-bit full add.
    s1      = a_sr_q[0] ^ b_sr_q[0];
    c1      = a_sr_q[0] & b_sr_q[0];
    sbit    = s1 ^ c_q;
    c2      = s1 & c_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
        acc_d  = (acc_q >> 1) | (WIDTH'(sbit) << (WIDTH - 1));
        c_d    = c1 | c2;
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        sum_d   = acc_q;
        cout_d  = c_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 main instance plus a WIDTH=1 instance.
// Inputs change and outputs are sampled on the falling edge.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done;
  logic [7:0] sum;
  logic       cout;

  logic       start1;
  logic [0:0] a1, b1;
  logic       cin1;
  logic       busy1, done1;
  logic [0:0] sum1;
  logic       cout1;

  int checks;
  int failures;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents operands with start for one edge; returns on the falling edge after acceptance.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl: busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (sum !== 8'h00 || cout !== 1'b0) begin
      failures++; $display("FAIL reset_result: sum=%h cout=%b required 00 0", sum, cout);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int busy_cycles;
    start_op(8'h5A, 8'h3C, 1'b0);
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 20) begin
      checks++;
      if (done !== 1'b0) begin
        failures++; $display("FAIL basic_busy_done_overlap: done=%b during busy", done);
      end
      busy_cycles++;
      @(negedge clk);
    end
    checks++;
    if (busy_cycles != 8) begin
      failures++; $display("FAIL basic_busy_len: got %0d cycles required 8", busy_cycles);
    end
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL basic_done_pulse: done=%b required 1", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL basic_done_single: done=%b required 0", done);
    end
    checks++;
    if (sum !== 8'h96 || cout !== 1'b0) begin
      failures++; $display("FAIL basic_result: sum=%h cout=%b required 96 0", sum, cout);
    end
  endtask

  task automatic test_ripple;
    start_op(8'hFF, 8'h01, 1'b0);
    repeat (8) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL ripple_done: done=%b required 1", done);
    end
    @(negedge clk);
    checks++;
    if (sum !== 8'h00 || cout !== 1'b1) begin
      failures++; $display("FAIL ripple_result: sum=%h cout=%b required 00 1", sum, cout);
    end
  endtask

  task automatic test_hold_during_busy;
    start_op(8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (sum !== 8'h00 || cout !== 1'b1) begin
        failures++; $display("FAIL hold_prev_result cycle %0d: sum=%h cout=%b required 00 1", i, sum, cout);
      end
      @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (sum !== 8'hFF || cout !== 1'b1) begin
      failures++; $display("FAIL all_ones_result: sum=%h cout=%b required ff 1", sum, cout);
    end
  endtask

  // start held high; operands scrambled every cycle except the one before each accept.
  task automatic test_back_to_back;
    logic exp_busy, exp_done;
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    for (int j = 1; j <= 20; j++) begin
      exp_busy = (j >= 1 && j <= 8) || (j >= 11 && j <= 18);
      exp_done = (j == 9) || (j == 19);
      checks++;
      if (busy !== exp_busy || done !== exp_done) begin
        failures++;
        $display("FAIL b2b_ctrl cycle %0d: busy=%b done=%b required %b %b", j, busy, done, exp_busy, exp_done);
      end
      if (j == 10) begin
        checks++;
        if (sum !== 8'h33 || cout !== 1'b0) begin
          failures++; $display("FAIL b2b_first_result: sum=%h cout=%b required 33 0", sum, cout);
        end
        a = 8'h40; b = 8'h05; cin = 1'b1;
      end else begin
        a = 8'(j * 37 + 3); b = 8'(j * 91 + 7); cin = j[0];
      end
      if (j == 11) start = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (sum !== 8'h46 || cout !== 1'b0) begin
      failures++; $display("FAIL b2b_second_result: sum=%h cout=%b required 46 0", sum, cout);
    end
  endtask

  task automatic test_reset_mid_op;
    int seen_done;
    start_op(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: busy=%b done=%b sum=%h cout=%b required 0 0 00 0", busy, done, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      failures++; $display("FAIL reset_no_done: got %0d busy/done cycles required 0", seen_done);
    end
    start_op(8'h12, 8'h34, 1'b0);
    repeat (8) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sum !== 8'h46 || cout !== 1'b0) begin
      failures++; $display("FAIL after_reset_result: sum=%h cout=%b required 46 0", sum, cout);
    end
  endtask

  task automatic test_width1;
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      failures++; $display("FAIL w1_busy: busy=%b done=%b required 1 0", busy1, done1);
    end
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b1) begin
      failures++; $display("FAIL w1_done: busy=%b done=%b required 0 1", busy1, done1);
    end
    @(negedge clk);
    checks++;
    if (sum1 !== 1'b1 || cout1 !== 1'b1 || done1 !== 1'b0) begin
      failures++; $display("FAIL w1_result: sum=%b cout=%b done=%b required 1 1 0", sum1, cout1, done1);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_ripple();
    test_hold_during_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
